// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with single outstanding request and 2-entry output FIFO
//
// Purpose: requests instruction words from instruction memory, buffers up to
// two {pc, instr} pairs and presents them to the decode stage. Redirects flush
// the buffer and restart fetch; a response to a request issued before a
// redirect is dropped.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_ready                   memory accepts the request this cycle
//   imem_rvalid, imem_rdata      read response
//   redirect, redirect_pc        restart fetch at redirect_pc (bits [1:0] ignored)
//   out_valid, out_instr, out_pc instruction presented to decode (FIFO head)
//   out_ready                    decode consumes the head this cycle

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_next;
  logic [31:0] req_pc;
  logic [31:0] redirect_addr;

  // Shift-style FIFO: entry 0 is always the head and drives the outputs directly.
  logic [31:0] e0_pc;
  logic [31:0] e0_instr;
  logic [31:0] e1_pc;
  logic [31:0] e1_instr;
  logic [1:0]  count;

  logic accept;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign redirect_addr        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_addr = {fetch_pc[31:2], 2'b00};
  // count <= 1 guarantees room for the single outstanding response.
  assign imem_req  = (state == S_REQ) && (count <= 2'd1) && !rst;
  assign accept    = imem_req && imem_ready;

  // Redirect overrides both ends of the FIFO in the same cycle.
  assign push = (state == S_WAIT) && imem_rvalid && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  assign out_valid = (count != 2'd0);
  assign out_pc    = e0_pc;
  assign out_instr = e0_instr;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    case (state)
      S_REQ: begin
        if (accept) begin
          // A request accepted alongside a redirect is already stale.
          state_next    = redirect ? S_DISCARD : S_WAIT;
          fetch_pc_next = fetch_pc + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_next = S_REQ;
        end else if (redirect) begin
          state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
    if (redirect) begin
      fetch_pc_next = redirect_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      if (accept) begin
        req_pc <= imem_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      e0_pc    <= RESET_PC;
      e0_instr <= NOP;
      e1_pc    <= RESET_PC;
      e1_instr <= NOP;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e0_pc    <= req_pc;
            e0_instr <= imem_rdata;
          end else begin
            e1_pc    <= req_pc;
            e1_instr <= imem_rdata;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          e0_pc    <= e1_pc;
          e0_instr <= e1_instr;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0_pc    <= req_pc;
            e0_instr <= imem_rdata;
          end else begin
            e0_pc    <= e1_pc;
            e0_instr <= e1_instr;
            e1_pc    <= req_pc;
            e1_instr <= imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] sb[$];
  logic        mem_auto;
  logic        pend;
  logic [31:0] pend_addr;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE5A00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc);
    sb.push_back({pc, mdata(pc)});
  endtask

  // One clock: memory model drives its response, outputs are checked before the
  // rising edge, then returns at the following falling edge.
  task automatic cycle();
    logic [63:0] e;
    if (mem_auto) begin
      imem_rvalid = pend;
      imem_rdata  = pend ? mdata(pend_addr) : 32'h0;
    end
    #1;
    if (redirect) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_out: observed pc %h, expected no output", out_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e[63:32]);
        chk("out_instr", out_instr, e[31:0]);
      end
    end
    n_assert++;
    assert (!(dut.push && dut.count == 2'd2)) else begin
      n_fail++;
      $error("FAIL push_when_full: observed count %0d, expected push only below 2", dut.count);
    end
    pend      = imem_req && imem_ready;
    pend_addr = imem_addr;
    @(negedge clk);
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d pending, expected 0", tag, sb.size());
    end
  endtask

  task automatic reset_dut();
    rst         = 1'b1;
    redirect    = 1'b0;
    out_ready   = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    mem_auto    = 1'b1;
    sb.delete();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mem_auto    = 1'b1;
    pend        = 1'b0;
    pend_addr   = 32'h0;

    // Reset state
    cycle();
    cycle();
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_pc", out_pc, RESET_PC);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    rst = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);

    // Sequential fetch
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    expect_out(32'h0);
    expect_out(32'h4);
    expect_out(32'h8);
    expect_out(32'hC);
    run_until_empty("seq", 40);

    // Backpressure
    reset_dut();
    imem_ready = 1'b1;
    repeat (10) cycle();
    chk("bp_imem_req", {31'b0, imem_req}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_head_instr", out_instr, mdata(32'h0));
    chk("bp_fetch_addr", imem_addr, 32'h8);
    expect_out(32'h0);
    expect_out(32'h4);
    expect_out(32'h8);
    out_ready = 1'b1;
    run_until_empty("bp", 40);

    // Redirect in WAIT, response arriving later in DISCARD
    reset_dut();
    imem_ready  = 1'b1;
    out_ready   = 1'b1;
    mem_auto    = 1'b0;
    imem_rvalid = 1'b0;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h00000100;
    cycle();
    redirect = 1'b0;
    chk("rw_discard_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    cycle();
    imem_rvalid = 1'b0;
    chk("rw_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rw_req", {31'b0, imem_req}, 32'd1);
    chk("rw_addr", imem_addr, 32'h100);
    mem_auto = 1'b1;
    expect_out(32'h100);
    expect_out(32'h104);
    run_until_empty("rw", 40);

    // Redirect in WAIT together with the response
    reset_dut();
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h00000200;
    cycle();
    redirect = 1'b0;
    chk("rwv_req", {31'b0, imem_req}, 32'd1);
    chk("rwv_addr", imem_addr, 32'h200);
    expect_out(32'h200);
    run_until_empty("rwv", 40);

    // Redirect coinciding with accept at 0x8
    reset_dut();
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    expect_out(32'h0);
    expect_out(32'h4);
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 20) begin
      cycle();
      n++;
    end
    chk("ra_reach_8", imem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h00000040;
    cycle();
    redirect = 1'b0;
    chk("ra_discard_req", {31'b0, imem_req}, 32'd0);
    chk("ra_addr", imem_addr, 32'h40);
    expect_out(32'h40);
    expect_out(32'h44);
    run_until_empty("ra", 40);

    // Unaligned redirect without accept, then wrap
    reset_dut();
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFE;
    cycle();
    redirect = 1'b0;
    chk("wrap_req", {31'b0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    imem_ready = 1'b1;
    expect_out(32'hFFFFFFFC);
    expect_out(32'h00000000);
    expect_out(32'h00000004);
    run_until_empty("wrap", 40);

    // Reset while waiting; late response ignored
    reset_dut();
    imem_ready  = 1'b1;
    out_ready   = 1'b1;
    mem_auto    = 1'b0;
    imem_rvalid = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADBAD00;
    cycle();
    imem_rvalid = 1'b0;
    chk("rm_out_valid", {31'b0, out_valid}, 32'd0);
    mem_auto = 1'b1;
    expect_out(RESET_PC);
    expect_out(RESET_PC + 32'd4);
    run_until_empty("rm", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
